// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the CORDIC request scheduler.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int FRAC_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } cordic_state_e;

endpackage

// File: rtl/cordic_rr_arb.sv
// Combinational round-robin picker: scans upward from last_grant+1 (wrapping)
// and returns the first pending requester as one-hot plus its index.
module cordic_rr_arb
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_i) + k) % N_REQ);
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one CORDIC engine between N_REQ requesters (IDLE->START->WAIT->RESP).
// Define CORDIC_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with rsp_err=1.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [ANGLE_W*N_REQ-1:0] req_angle,
    input  logic [N_REQ-1:0]         req_radian_en,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [ANGLE_W-1:0]       rsp_sin,
    output logic [ANGLE_W-1:0]       rsp_cos,
    output logic [ANGLE_W-1:0]       rsp_tan,
    output logic [ANGLE_W-1:0]       rsp_cot,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     cord_start,
    output logic [ANGLE_W-1:0]       cord_angle,
    output logic                     cord_radian_en,
    input  logic [ANGLE_W-1:0]       cord_sin,
    input  logic [ANGLE_W-1:0]       cord_cos,
    input  logic [ANGLE_W-1:0]       cord_tan,
    input  logic [ANGLE_W-1:0]       cord_cot,
    input  logic                     cord_done,
    output logic [1:0]               dbg_state_o
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("cordic_sched: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    cordic_state_e          state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [ANGLE_W-1:0]     angle_q, angle_d;
    logic                   rad_q, rad_d;
    logic                   armed_q, armed_d;
    logic [4*ANGLE_W-1:0]   res_q, res_d;

    logic [N_REQ-1:0]       win;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;

    cordic_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i        (req),
        .last_grant_i (last_q),
        .gnt_o        (win),
        .gnt_idx_o    (win_idx),
        .any_o        (win_any)
    );

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        angle_d = angle_q;
        rad_d   = rad_q;
        armed_d = armed_q;
        res_d   = res_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_START;
                    last_d  = win_idx;
                    owner_d = win_idx;
                    angle_d = req_angle[int'(win_idx)*ANGLE_W +: ANGLE_W];
                    rad_d   = req_radian_en[win_idx];
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                armed_d = 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                // Only a low sample taken in WAIT arms completion, so a done
                // level left over from the previous job is never mistaken for ours.
                if (!cord_done) begin
                    armed_d = 1'b1;
                end
                if (armed_q && cord_done) begin
                    state_d = ST_RESP;
                    res_d   = {cord_sin, cord_cos, cord_tan, cord_cot};
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                    res_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(N_REQ - 1);
            owner_q <= '0;
            angle_q <= '0;
            rad_q   <= 1'b0;
            armed_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            angle_q <= angle_d;
            rad_q   <= rad_d;
            armed_q <= armed_d;
            res_q   <= res_d;
        end
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = (state_q == ST_RESP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // gnt is gated by rst so a request held through reset shows nothing.
    assign gnt            = (state_q == ST_IDLE && rst) ? win : '0;
    assign rsp_valid      = (state_q == ST_RESP) ? (N_REQ'(1) << owner_q) : '0;
    assign busy           = (state_q != ST_IDLE);
    assign cord_start     = (state_q == ST_START);
    assign cord_angle     = angle_q;
    assign cord_radian_en = rad_q;
    assign {rsp_sin, rsp_cos, rsp_tan, rsp_cot} = res_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched with a behavioural engine model.
module tb_cordic_sched;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;
    localparam int EXP_W   = 68;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req = '0;
    logic [16*N_REQ-1:0]  req_angle = '0;
    logic [N_REQ-1:0]     req_radian_en = '0;
    logic [N_REQ-1:0]     gnt, rsp_valid;
    logic [15:0]          rsp_sin, rsp_cos, rsp_tan, rsp_cot;
    logic                 rsp_err, busy, cord_start, cord_radian_en;
    logic [15:0]          cord_angle;
    logic [15:0]          cord_sin, cord_cos, cord_tan, cord_cot;
    logic                 cord_done;
    logic [1:0]           dbg_state_o;

    cordic_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_angle(req_angle),
        .req_radian_en(req_radian_en), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_tan(rsp_tan), .rsp_cot(rsp_cot),
        .rsp_err(rsp_err), .busy(busy), .cord_start(cord_start),
        .cord_angle(cord_angle), .cord_radian_en(cord_radian_en),
        .cord_sin(cord_sin), .cord_cos(cord_cos), .cord_tan(cord_tan),
        .cord_cot(cord_cot), .cord_done(cord_done), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- engine model ----------------
    function automatic logic [63:0] model(input logic [15:0] a, input logic r);
        logic [15:0] s, c, t, k;
        s = a + 16'h0101;
        c = ~a;
        t = {a[7:0], a[15:8]};
        k = a ^ (r ? 16'hFFFF : 16'h5A5A);
        return {s, c, t, k};
    endfunction

    logic        eng_manual = 1'b0;
    logic        man_done   = 1'b0;
    logic        eng_done   = 1'b0;
    int          eng_lat    = 1;
    int          eng_cnt    = 0;
    logic [15:0] eng_ang    = '0;
    logic        eng_rad    = 1'b0;

    always @(posedge clk) begin
        if (cord_start) begin
            eng_cnt  <= eng_lat;
            eng_done <= 1'b0;
            eng_ang  <= cord_angle;
            eng_rad  <= cord_radian_en;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_done <= 1'b1;
        end
    end

    assign cord_done = eng_manual ? man_done : eng_done;
    assign {cord_sin, cord_cos, cord_tan, cord_cot} = model(eng_ang, eng_rad);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [EXP_W-1:0] act,
                         input logic [EXP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin : mon
        logic [EXP_W-1:0] e;
        int ridx;
        if (rsp_valid != '0) begin
            ridx = idx_of(rsp_valid);
            check("rsp_onehot", EXP_W'($onehot(rsp_valid)), EXP_W'(1));
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", EXP_W'(rsp_valid), '0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", {3'(ridx), rsp_err, rsp_sin, rsp_cos, rsp_tan, rsp_cot}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int idx, input logic [15:0] ang, input logic rad);
        req_angle[idx*16 +: 16] = ang;
        req_radian_en[idx]      = rad;
        req[idx]                = 1'b1;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_valid == '0 && cyc < 300);
    endtask

    task automatic run_single(input int idx, input logic [15:0] ang, input logic rad,
                              input int lat, input int exp_cyc, input string name);
        int cyc;
        @(negedge clk);
        eng_lat = lat;
        set_req(idx, ang, rad);
        exp_q.push_back({3'(idx), 1'b0, model(ang, rad)});
        #1;
        check({name, "_gnt"}, EXP_W'(gnt), EXP_W'(N_REQ'(1) << idx));
        @(posedge clk);
        #1;
        req[idx] = 1'b0;
        check({name, "_start"}, {cord_start, busy, cord_radian_en, cord_angle},
              {1'b1, 1'b1, rad, ang});
        wait_rsp(cyc);
        check({name, "_lat"}, EXP_W'(cyc), EXP_W'(exp_cyc));
        @(negedge clk);
        check({name, "_idle"}, EXP_W'(busy), '0);
    endtask

    typedef struct {
        int          idx;
        logic [15:0] ang;
        logic        rad;
        int          lat;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin : main
        int got[5];
        int gcyc[5];
        int exp_order[5];
        logic [15:0] ord_ang[4];
        int ng, t, cyc, early;

        vecs[0] = '{0, 16'h0000, 1'b0, 10, 13};
        vecs[1] = '{1, 16'h1680, 1'b0, 1, 4};
        vecs[2] = '{3, 16'hFF00, 1'b1, 5, 8};
        vecs[3] = '{2, 16'h7FFF, 1'b1, 2, 5};
        vecs[4] = '{0, 16'h8000, 1'b0, 3, 6};
        vecs[5] = '{1, 16'h0324, 1'b1, 7, 10};
        exp_order = '{0, 1, 2, 3, 0};
        ord_ang   = '{16'h1100, 16'h2200, 16'h3300, 16'h4400};

        // reset: request held during reset must not show a grant
        rst = 1'b0;
        req = 4'b0001;
        repeat (3) @(negedge clk);
        check("reset_ctl", {gnt, rsp_valid, rsp_err, busy, cord_start, cord_radian_en, cord_angle}, '0);
        check("reset_bus", {rsp_sin, rsp_cos, rsp_tan, rsp_cot}, '0);
        check("reset_state", EXP_W'(dbg_state_o), '0);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // all four held: 0,1,2,3,0 with back-to-back grant spacing
        eng_lat = 2;
        for (int i = 0; i < N_REQ; i++) set_req(i, ord_ang[i], (i % 2) == 1);
        for (int i = 0; i < 5; i++) begin
            got[i]  = -1;
            gcyc[i] = -1;
            exp_q.push_back({3'(exp_order[i]), 1'b0,
                             model(ord_ang[exp_order[i]], (exp_order[i] % 2) == 1)});
        end
        ng = 0;
        t  = 0;
        while (ng < 5 && t < 200) begin
            #1;
            if (gnt != '0) begin
                got[ng]  = idx_of(gnt);
                gcyc[ng] = t;
                ng++;
                if (ng == 5) begin
                    @(posedge clk);
                    #1;
                    req = '0;
                end
            end
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) check($sformatf("order_%0d", i), EXP_W'(got[i]), EXP_W'(exp_order[i]));
        for (int i = 1; i < 5; i++) check($sformatf("b2b_gap_%0d", i), EXP_W'(gcyc[i] - gcyc[i-1]), EXP_W'(6));
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("order_drain", EXP_W'(exp_q.size()), '0);

        // table of single transactions
        for (int i = 0; i < 6; i++)
            run_single(vecs[i].idx, vecs[i].ang, vecs[i].rad, vecs[i].lat, vecs[i].exp_cyc,
                       $sformatf("vec%0d", i));

        // random single transactions
        for (int i = 0; i < 6; i++) begin
            int ri, rl;
            ri = $urandom_range(0, N_REQ - 1);
            rl = $urandom_range(1, 12);
            run_single(ri, 16'($urandom), 1'($urandom_range(0, 1)), rl, rl + 3,
                       $sformatf("rnd%0d", i));
        end

        // done already high on WAIT entry, low 3 cycles, then high again
        @(negedge clk);
        eng_manual = 1'b1;
        man_done   = 1'b1;
        set_req(1, 16'h2D00, 1'b0);
        exp_q.push_back({3'd1, 1'b0, model(16'h2D00, 1'b0)});
        #1;
        check("stuck_gnt", EXP_W'(gnt), EXP_W'(4'b0010));
        early = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) early++;
            if (k == 1) req[1] = 1'b0;
            man_done = (k >= 4 && k <= 6) ? 1'b0 : 1'b1;
        end
        wait_rsp(cyc);
        check("stuck_early", EXP_W'(early), '0);
        check("stuck_lat", EXP_W'(cyc), EXP_W'(1));
        @(negedge clk);
        eng_manual = 1'b0;
        man_done   = 1'b0;

`ifdef CORDIC_SCHED_TIMEOUT_EN
        // engine never finishes: abort 64 cycles after WAIT entry
        @(negedge clk);
        eng_manual = 1'b1;
        man_done   = 1'b0;
        set_req(3, 16'h4321, 1'b0);
        exp_q.push_back({3'd3, 1'b1, 64'h0});
        @(posedge clk);
        #1;
        req[3] = 1'b0;
        wait_rsp(cyc);
        check("timeout_lat", EXP_W'(cyc), EXP_W'(TIMEOUT + 2));
        @(negedge clk);
        eng_manual = 1'b0;
`endif

        // reset in the middle of WAIT abandons the job
        @(negedge clk);
        eng_lat = 20;
        set_req(0, 16'h1234, 1'b1);
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_busy", EXP_W'(busy), EXP_W'(1));
        rst = 1'b0;
        #1;
        check("midrst_ctl", {gnt, rsp_valid, rsp_err, busy, cord_start, cord_radian_en, cord_angle}, '0);
        check("midrst_bus", {rsp_sin, rsp_cos, rsp_tan, rsp_cot}, '0);
        @(posedge clk);
        #1;
        check("midrst_ctl_edge", {gnt, rsp_valid, rsp_err, busy, cord_start, cord_radian_en, cord_angle}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        run_single(2, 16'h0A00, 1'b0, 4, 7, "post_rst");

        repeat (5) @(negedge clk);
        check("final_queue_empty", EXP_W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one cordic engine (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64: max WAIT cycles before abort (timeout build only).
REQ-003 SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- req_angle  in  16*N_REQ  Q8.8 signed angle, slice i for requester i.
- req_radian_en  in  N_REQ  1=angle in radians, 0=degrees.
- gnt  out  N_REQ  one-hot accept pulse.
- rsp_valid  out  N_REQ  one-hot result pulse.
- rsp_sin/rsp_cos/rsp_tan/rsp_cot  out  16 each  shared result buses.
- rsp_err  out  1  result aborted.
- busy  out  1  engine owned.
- cord_start  out  1  one-cycle launch pulse to engine.
- cord_angle  out  16  angle to engine.
- cord_radian_en  out  1  unit select to engine.
- cord_sin/cord_cos/cord_tan/cord_cot  in  16 each  engine results.
- cord_done  in  1  engine completion level.

Function
REQ-004 SHALL implement FSM IDLE -> START -> WAIT -> RESP -> IDLE.
REQ-005 In IDLE with any req high, SHALL pulse gnt for the round-robin winner for one cycle, capture its angle/radian_en into cord_angle/cord_radian_en, go to START.
REQ-006 Round-robin SHALL search from (last_grant+1) mod N_REQ upward; requester not re-granted while another is pending.
REQ-007 Requester SHALL hold req until gnt; req dropped before gnt SHALL be ignored without side effects.
REQ-008 START SHALL last exactly one cycle with cord_start=1; cord_angle/cord_radian_en SHALL stay stable from START until leaving WAIT.
REQ-009 WAIT SHALL exit on a rising edge of cord_done (low then high as sampled in WAIT); done already high on WAIT entry SHALL not count.
REQ-010 On exit from WAIT, SHALL register cord_* results into rsp_* and enter RESP.
REQ-011 RESP SHALL last one cycle: rsp_valid[owner]=1, rsp_err as determined; rsp_* buses SHALL hold until next RESP.
REQ-012 busy SHALL be 1 in START, WAIT, RESP; 0 in IDLE.
REQ-013 Min latency gnt -> rsp_valid = engine latency + 3 cycles; back-to-back requests SHALL see gnt at the earliest in the cycle after RESP.
REQ-014 req high for the current owner during WAIT/RESP SHALL be treated as a new request in next IDLE.

Reset
REQ-015 On rst low: state=IDLE, last_grant=N_REQ-1 (requester 0 wins first), all outputs 0, rsp_* buses 0.
REQ-016 Reset mid-operation SHALL abandon the operation with no rsp_valid; engine state is not guaranteed.

Configuration
REQ-017 With CORDIC_SCHED_TIMEOUT_EN defined: WAIT counter SHALL abort after TIMEOUT cycles without done, entering RESP with rsp_err=1 and rsp_* buses 0.
REQ-018 Without CORDIC_SCHED_TIMEOUT_EN: no counter; WAIT waits indefinitely; rsp_err SHALL be constant 0.

Structure
REQ-019 Package cordic_pkg SHALL hold ANGLE_W=16, Q8.8 fraction width 8, and the FSM state enum.
REQ-020 Round-robin selection SHALL be sub-module cordic_rr_arb (req, last_grant -> one-hot winner, combinational).

Verification
REQ-021 Single req[0], angle 16'h0000 degrees, engine done after 10 cycles -> gnt[0] cycle 1, cord_start cycle 2, rsp_valid[0] 13 cycles after gnt, results match engine.
REQ-022 All four req high together, held -> grant order 0,1,2,3,0; no requester granted twice before all served.
REQ-023 cord_done stuck high entering WAIT, then low 3 cycles, then high -> completion taken only on the later rising edge.
REQ-024 Timeout build, TIMEOUT=64, done never asserted -> rsp_valid with rsp_err=1 exactly 64 cycles after WAIT entry; buses 0.
REQ-025 rst low during WAIT -> all outputs 0 next edge, no rsp_valid; after release req[2] alone -> gnt[2].
